// File: rtl/display_scheduler.sv
// display_scheduler: picks which status message the LCD writer shows next from
// the sticky display bits, holds each accepted message for DWELL cycles and rotates.
module display_scheduler #(
   parameter int unsigned DWELL = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] display,
   output logic        msg_valid,
   output logic [3:0]  msg_id,
   input  logic        msg_ack,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   // Handshake: msg_id is offered while msg_valid=1 and held stable until msg_ack
   // is sampled high on a rising edge; msg_ack while msg_valid=0 has no effect.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_SEND   = 2'd2,
      S_DWELL  = 2'd3
   } state_t;

   localparam logic [25:0] DWELL_LOAD = 26'(DWELL - 1);
   localparam logic [3:0]  BLANK_ID   = 4'd15;

   state_t      state;
   logic [10:0] snap;
   logic [3:0]  last_id;
   logic [25:0] cnt;
   logic        changed;
   logic        rotate;
   logic [3:0]  sel_id;

   // Next set index strictly after last, wrapping 10->0; the error bit wins outright.
   function automatic logic [3:0] pick(input logic [10:0] d, input logic [3:0] last);
      logic [4:0] start;
      logic [4:0] idx;
      logic [3:0] res;
      logic       found;
      start = (last >= 4'd10) ? 5'd0 : {1'b0, last} + 5'd1;
      res   = BLANK_ID;
      found = 1'b0;
      idx   = 5'd0;
      for (int k = 0; k < 11; k++) begin
         idx = start + 5'(k);
         if (idx > 5'd10) idx = idx - 5'd11;
         if (!found && d[idx[3:0]]) begin
            res   = idx[3:0];
            found = 1'b1;
         end
      end
      if (d[8]) res = 4'd8;
      return res;
   endfunction

   assign changed   = (display != snap);
   assign rotate    = snap[8] || ($countones(snap) > 1);
   assign sel_id    = pick(display, last_id);
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         msg_valid <= 1'b0;
         msg_id    <= BLANK_ID;
         busy      <= 1'b0;
         snap      <= 11'd0;
         last_id   <= BLANK_ID;
         cnt       <= 26'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (changed) begin
                  state <= S_SELECT;
                  busy  <= 1'b1;
               end
            end
            S_SELECT: begin
               snap      <= display;
               msg_id    <= sel_id;
               msg_valid <= 1'b1;
               state     <= S_SEND;
            end
            S_SEND: begin
               if (msg_ack) begin
                  last_id   <= msg_id;
                  msg_valid <= 1'b0;
                  if (msg_id == BLANK_ID) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_DWELL;
                     cnt   <= DWELL_LOAD;
                  end
               end
            end
            S_DWELL: begin
               if (cnt != 26'd0) cnt <= cnt - 26'd1;
               // A fresh display change takes priority over the end of the dwell.
               if (changed || (cnt == 26'd0 && rotate)) begin
                  state <= S_SELECT;
               end else if (cnt == 26'd0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed and randomized display sequences; a queue of expected
// offers (id and cycle) is filled by the driver and drained by an independent monitor.
module tb_display_scheduler;

   localparam int DWELL_P = 4;
   localparam int INF     = 32'h7fff_ffff;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] display;
   logic        msg_valid;
   logic [3:0]  msg_id;
   logic        msg_ack;
   logic        busy;
   logic [1:0]  state_dbg;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [3:0]  exp_q[$];
   int          exp_t_q[$];

   // Reference model: what the screen was last told, what was last accepted,
   // what is currently expected on offer, and from which cycle the block idles.
   logic [10:0] m_snap;
   logic [3:0]  m_last;
   logic [3:0]  m_cur;
   int          idle_from;

   logic [3:0]  mon_exp;
   int          mon_t;
   logic        mon_prev;

   display_scheduler #(.DWELL(DWELL_P)) dut (
      .clk       (clk),
      .reset     (reset),
      .display   (display),
      .msg_valid (msg_valid),
      .msg_id    (msg_id),
      .msg_ack   (msg_ack),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] next_id(input logic [10:0] d, input logic [3:0] last);
      int set_q[$];
      if (d[8]) return 4'd8;
      if (d == 11'd0) return 4'd15;
      for (int i = 0; i < 11; i++) if (d[i]) set_q.push_back(i);
      foreach (set_q[j]) if (set_q[j] > int'(last)) return 4'(set_q[j]);
      return 4'(set_q[0]);
   endfunction

   function automatic bit is_rep(input logic [10:0] d);
      return d[8] || ($countones(d) > 1);
   endfunction

   function automatic logic [10:0] rand_disp(input logic [10:0] avoid);
      logic [10:0] d;
      int kind;
      do begin
         kind = $urandom_range(0, 9);
         if (kind == 0) d = 11'd0;
         else if (kind <= 3) d = 11'd1 << $urandom_range(0, 10);
         else begin
            d = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) != 0) d[8] = 1'b0;
         end
      end while (d == avoid);
      return d;
   endfunction

   task automatic push_exp(input logic [3:0] id, input int t);
      exp_q.push_back(id);
      exp_t_q.push_back(t);
      m_cur = id;
   endtask

   // Idle cycles with stray acks while no message is on offer.
   task automatic gap(input int r);
      repeat (r) begin
         msg_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      msg_ack = 1'b0;
   endtask

   task automatic apply(input logic [10:0] d);
      chk("busy_before_change", int'(busy), (cyc < idle_from) ? 1 : 0);
      display = d;
      push_exp(next_id(d, m_last), cyc + 2);
      m_snap    = d;
      idle_from = INF;
   endtask

   task automatic wait_offer();
      int w;
      w = 0;
      while (!msg_valid && w < 40) begin
         msg_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         w++;
      end
      msg_ack = 1'b0;
      chk("offer_timeout", int'(msg_valid), 1);
   endtask

   task automatic take_offers(input int n, input int ack_max);
      int a;
      logic [3:0] nid;
      for (int k = 0; k < n; k++) begin
         wait_offer();
         repeat ($urandom_range(0, ack_max)) @(negedge clk);
         msg_ack = 1'b1;
         a = cyc;
         @(negedge clk);
         msg_ack = 1'b0;
         m_last = m_cur;
         if (k < n - 1) begin
            nid = next_id(m_snap, m_last);
            push_exp(nid, a + DWELL_P + 2);
            idle_from = INF;
         end else if (m_snap == 11'd0) idle_from = a + 1;
         else if (!is_rep(m_snap)) idle_from = a + DWELL_P + 1;
         else idle_from = INF;
      end
   endtask

   // Change the display while the current offer is still unacknowledged.
   task automatic take_change(input logic [10:0] new_d, input int hold);
      int a;
      wait_offer();
      display = new_d;
      repeat (hold) @(negedge clk);
      msg_ack = 1'b1;
      a = cyc;
      @(negedge clk);
      msg_ack = 1'b0;
      m_last = m_cur;
      push_exp(next_id(new_d, m_last), a + 3);
      m_snap    = new_d;
      idle_from = INF;
   endtask

   initial begin
      mon_prev = 1'b0;
      mon_exp  = 4'd15;
      forever begin
         @(negedge clk);
         if (msg_valid && !mon_prev) begin
            if (exp_q.size() == 0) chk("unexpected_offer", int'(msg_valid), 0);
            else begin
               mon_exp = exp_q.pop_front();
               mon_t   = exp_t_q.pop_front();
               chk("msg_id", int'(msg_id), int'(mon_exp));
               chk("offer_cycle", cyc, mon_t);
               chk("busy_in_send", int'(busy), 1);
            end
         end else if (msg_valid) begin
            chk("msg_id_hold", int'(msg_id), int'(mon_exp));
         end
         mon_prev = msg_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      display   = 11'd0;
      msg_ack   = 1'b0;
      reset     = 1'b1;
      m_snap    = 11'd0;
      m_last    = 4'd15;
      m_cur     = 4'd15;
      idle_from = 0;
      repeat (3) @(negedge clk);
      chk("rst_valid", int'(msg_valid), 0);
      chk("rst_id", int'(msg_id), 15);
      chk("rst_busy", int'(busy), 0);
      reset = 1'b0;
      @(negedge clk);

      // Single message: shown once, then back to idle with no resend.
      apply(11'h001);
      take_offers(1, 0);
      gap(DWELL_P - 1);
      chk("busy_last_dwell", int'(busy), 1);
      gap(1);
      chk("busy_after_dwell", int'(busy), 0);
      gap(3);

      // Rotation 1,5,7,1 with immediate acks.
      apply(11'h0A2);
      take_offers(4, 0);
      gap(2);

      // Ack withheld while the display changes underneath the offer.
      apply(11'h001);
      take_change(11'h002, 10);
      take_offers(1, 2);
      gap(1);

      // Error bit preempts the other bits and repeats.
      apply(11'h121);
      take_offers(3, 1);

      // Display cleared during a dwell: blank screen, then idle.
      apply(11'h001);
      take_offers(1, 0);
      gap(1);
      apply(11'h000);
      take_offers(1, 0);
      chk("busy_after_blank", int'(busy), 0);
      gap(2);

      for (int it = 0; it < 40; it++) begin
         int r;
         int n;
         logic [10:0] d;
         r = is_rep(m_snap) ? $urandom_range(0, DWELL_P - 1) : $urandom_range(0, DWELL_P + 3);
         gap(r);
         d = rand_disp(m_snap);
         apply(d);
         n = is_rep(d) ? $urandom_range(1, 3) : 1;
         take_offers(n, 3);
      end

      gap(is_rep(m_snap) ? $urandom_range(0, DWELL_P - 1) : 1);
      apply((m_snap != 11'd0) ? 11'h000 : 11'h004);
      take_offers(1, 1);
      gap(DWELL_P + 2);
      chk("final_idle_busy", int'(busy), 0);
      chk("queue_drained", exp_q.size(), 0);

      // Reset in the middle of an unacknowledged offer.
      apply(11'h040);
      wait_offer();
      repeat (2) @(negedge clk);
      reset   = 1'b1;
      display = 11'd0;
      @(negedge clk);
      reset = 1'b0;
      chk("midsend_rst_valid", int'(msg_valid), 0);
      chk("midsend_rst_id", int'(msg_id), 15);
      chk("midsend_rst_busy", int'(busy), 0);
      m_snap    = 11'd0;
      m_last    = 4'd15;
      m_cur     = 4'd15;
      idle_from = 0;
      gap(2);

      apply(11'h010);
      take_offers(1, 1);
      gap(DWELL_P + 2);
      chk("post_rst_idle", int'(busy), 0);
      chk("queue_empty_end", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
